// File: rtl/ps2_key_tracker_pkg.sv
// -----------------------------------------------------------------------------
// ps2_key_pkg
// Shared definitions for the PS/2 key tracker: scan-code prefix constants,
// the prefix parser state type, the queued event record and the table of
// tracked keys. Table entry i maps {ext, make code} to the ASCII code reported
// to the game logic. The tracker uses only the first NUM_KEYS entries.
// -----------------------------------------------------------------------------
package ps2_key_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_TABLE_SIZE = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  typedef struct packed {
    logic [7:0] key;
    logic       is_release;
  } key_event_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } key_entry_t;

  // The arrow keys report the same ASCII codes as O/K so that either key set
  // moves the right-hand paddle.
  function automatic key_entry_t key_table(input int idx);
    key_entry_t e;
    case (idx)
      0:       e = '{ext: 1'b0, code: 8'h1D, ascii: 8'h57};  // W
      1:       e = '{ext: 1'b0, code: 8'h1B, ascii: 8'h53};  // S
      2:       e = '{ext: 1'b1, code: 8'h75, ascii: 8'h4F};  // Up   -> O
      3:       e = '{ext: 1'b1, code: 8'h72, ascii: 8'h4B};  // Down -> K
      4:       e = '{ext: 1'b0, code: 8'h44, ascii: 8'h4F};  // O
      5:       e = '{ext: 1'b0, code: 8'h42, ascii: 8'h4B};  // K
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// -----------------------------------------------------------------------------
// ps2_key_tracker_if
// Event stream from the key tracker to the game-control consumer.
//   evt_valid   : head event present (FIFO non-empty)
//   evt_ready   : consumer pop strobe; pops when evt_valid & evt_ready
//   evt_key     : ASCII code of head event
//   evt_release : head event is a release (1) or a press (0)
// master = tracker side, slave = consumer side.
// -----------------------------------------------------------------------------
interface ps2_key_tracker_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_key;
  logic       evt_release;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_tracker_fifo.sv
// -----------------------------------------------------------------------------
// ps2_event_fifo
// First-word-fall-through event FIFO with a sticky overflow flag.
// Ports:
//   inclock, reset : clock, synchronous active-high reset
//   push, push_data: enqueue request and event record
//   pop            : dequeue request (ignored while empty)
//   valid, head    : FIFO non-empty and head record (zero while empty)
//   overflow       : sticky; set when a push is dropped because full
// Pointers carry one wrap bit above the address bits so full and empty are
// distinguishable without a separate count.
// -----------------------------------------------------------------------------
import ps2_key_pkg::*;

module ps2_event_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       inclock,
  input  logic       reset,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output logic       valid,
  output key_event_t head,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  key_event_t    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A same-cycle pop frees the slot the push needs, so a full FIFO still
  // accepts a push when the consumer is draining.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge inclock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage is data only; the pointers define which entries are meaningful.
  always_ff @(posedge inclock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign valid = ~empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_tracker.sv
// -----------------------------------------------------------------------------
// ps2_key_tracker
// Parses the PS/2 byte stream (make codes, F0 break and E0 extended
// prefixes), keeps a held bitmap of the tracked keys for continuous paddle
// motion, and queues press/release events in a FWFT FIFO.
// Ports:
//   inclock, reset : 50 MHz clock, synchronous active-high reset
//   scan_code      : byte from PS2_Controller received_data
//   scan_ready     : received_data_en; a new byte is its rising edge
//   key_held       : bit i = 1 while table key i is down
//   evt_overflow   : sticky; an event was dropped because the FIFO was full
//   last_scan      : last raw byte accepted, prefixes included
//   evt            : event stream (master side of ps2_key_tracker_if)
// Build option: define TYPEMATIC_FILTER_EN to drop typematic repeats (a press
// of a key that is already held) instead of queueing them.
// -----------------------------------------------------------------------------
import ps2_key_pkg::*;

module ps2_key_tracker #(
  parameter int NUM_KEYS   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                inclock,
  input  logic                reset,
  input  logic [7:0]          scan_code,
  input  logic                scan_ready,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_overflow,
  output logic [7:0]          last_scan,
  ps2_key_tracker_if.master   evt
);

  parse_state_t        state_q;
  parse_state_t        state_d;
  logic                scan_ready_d;
  logic                strobe;
  logic                lookup_en;
  logic                lookup_ext;
  logic                lookup_rel;
  logic                hit;
  logic [NUM_KEYS-1:0] hit_mask;
  logic [7:0]          hit_ascii;
  logic                repeat_press;
  logic                accept;
  key_event_t          push_data;
  key_event_t          head;
  logic                fifo_valid;

  assign strobe = scan_ready & ~scan_ready_d;

  always_ff @(posedge inclock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Prefix parser. Repeated prefixes are absorbed, and F0 before E0 is
  // tolerated as an extended break.
  always_comb begin
    state_d    = state_q;
    lookup_en  = 1'b0;
    lookup_ext = 1'b0;
    lookup_rel = 1'b0;
    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == PS2_EXT)      state_d = ST_EXT;
          else if (scan_code == PS2_BRK) state_d = ST_BRK;
          else                           lookup_en = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (scan_code == PS2_EXT) state_d = ST_EXT;
          else begin
            lookup_en  = 1'b1;
            lookup_ext = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scan_code == PS2_EXT)      state_d = ST_EXT_BRK;
          else if (scan_code == PS2_BRK) state_d = ST_BRK;
          else begin
            lookup_en  = 1'b1;
            lookup_rel = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (scan_code == PS2_BRK || scan_code == PS2_EXT) begin
            state_d = ST_EXT_BRK;
          end else begin
            lookup_en  = 1'b1;
            lookup_ext = 1'b1;
            lookup_rel = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Table match on {ext, code}; unmatched bytes (unknown keys, E0 12
  // fake-shift) produce no event and leave the bitmap alone.
  always_comb begin
    key_entry_t entry;
    entry     = '0;
    hit       = 1'b0;
    hit_mask  = '0;
    hit_ascii = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      entry = key_table(i);
      if (!hit && entry.ext == lookup_ext && entry.code == scan_code) begin
        hit         = 1'b1;
        hit_mask[i] = 1'b1;
        hit_ascii   = entry.ascii;
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  assign repeat_press = ~lookup_rel & |(hit_mask & key_held);
`else
  assign repeat_press = 1'b0;
`endif

  assign accept    = lookup_en & hit & ~repeat_press;
  assign push_data = '{key: hit_ascii, is_release: lookup_rel};

  always_ff @(posedge inclock) begin
    if (reset) begin
      scan_ready_d <= 1'b0;
      key_held     <= '0;
      last_scan    <= '0;
    end else begin
      scan_ready_d <= scan_ready;
      if (strobe) last_scan <= scan_code;
      if (accept) begin
        if (lookup_rel) key_held <= key_held & ~hit_mask;
        else            key_held <= key_held | hit_mask;
      end
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .inclock   (inclock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (evt.evt_ready),
    .valid     (fifo_valid),
    .head      (head),
    .overflow  (evt_overflow)
  );

  assign evt.evt_valid   = fifo_valid;
  assign evt.evt_key     = head.key;
  assign evt.evt_release = head.is_release;

endmodule
